// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a
// req/rvalid handshake and presents it to decode until execute retires it.
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      OPcode,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            branch,
    input  logic            jump,
    input  logic            jalr,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            misalign_err,
    output logic [31:0]     instret
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [XLEN-1:0] LSB_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};

    logic [2:0]      state;
    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    // jalr has highest priority and always drops bit 0 of its target.
    function automatic logic [XLEN-1:0] select_next_pc(
        input logic            sel_jalr,
        input logic            sel_jump,
        input logic            sel_branch,
        input logic            taken,
        input logic [XLEN-1:0] cur_pc,
        input logic [XLEN-1:0] br_tgt,
        input logic [XLEN-1:0] jr_tgt
    );
        logic [XLEN-1:0] npc;
        if (sel_jalr)
            npc = jr_tgt & LSB_CLEAR;
        else if (sel_jump)
            npc = br_tgt;
        else if (sel_branch && taken)
            npc = br_tgt;
        else
            npc = cur_pc + XLEN'(4);
        return npc;
    endfunction

    assign next_pc = select_next_pc(jalr, jump, branch, branch_taken,
                                    pc, branch_target, jalr_target);
    assign next_misaligned = |next_pc[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            instr        <= NOP_INSTR;
            misalign_err <= 1'b0;
            instret      <= 32'd0;
        end else begin
            case (state)
                S_IDLE:  state <= S_FETCH;
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    // Responses are only honoured here, so strays are dropped.
                    if (imem_rvalid) begin
                        instr <= imem_rdata;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        instret <= instret + 32'd1;
                        instr   <= NOP_INSTR;
                        if (next_misaligned) begin
                            misalign_err <= 1'b1;
                            state        <= S_HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_ISSUE);
    assign OPcode      = instr[6:0];
    assign pc_plus4    = pc + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed next-PC table, hand-written handshake
// sequences and a randomized run against a transaction-level reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  OPcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch, jump, jalr, branch_taken;
    logic [31:0] branch_target, jalr_target;
    logic        misalign_err;
    logic [31:0] instret;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .OPcode(OPcode), .pc(pc), .pc_plus4(pc_plus4),
        .branch(branch), .jump(jump), .jalr(jalr), .branch_taken(branch_taken),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .misalign_err(misalign_err), .instret(instret)
    );

    typedef struct {
        logic [31:0] start;
        logic        br, jp, jr, tk;
        logic [31:0] bt, jt;
        logic [31:0] exp_pc;
        logic        err;
        logic [31:0] exp_ir;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Inputs are driven and outputs sampled right after the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_ctl();
        instr_ready = 0; branch = 0; jump = 0; jalr = 0; branch_taken = 0;
        branch_target = 0; jalr_target = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; imem_rvalid = 0; imem_rdata = 0; clr_ctl();
        tick();
        rst_n = 1;
    endtask

    task automatic wait_for_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("req_timeout", 32'(ok), 32'd1);
    endtask

    task automatic retire_with(input logic br, input logic jp, input logic jr, input logic tk,
                               input logic [31:0] bt, input logic [31:0] jt);
        bit ok;
        logic [31:0] a;
        wait_for_req(ok);
        if (!ok) return;
        a = imem_addr;
        tick();
        imem_rvalid = 1; imem_rdata = memword(a);
        tick();
        imem_rvalid = 0;
        chk("vec_issue_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1; branch = br; jump = jp; jalr = jr; branch_taken = tk;
        branch_target = bt; jalr_target = jt;
        tick();
        clr_ctl();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit ok;
        int reqs;
        do_reset();
        if (v.start != 0) retire_with(0, 1, 0, 0, v.start, 32'd0);
        retire_with(v.br, v.jp, v.jr, v.tk, v.bt, v.jt);
        if (!v.err) begin
            wait_for_req(ok);
            if (ok) chk($sformatf("vec%0d_next_addr", idx), imem_addr, v.exp_pc);
            chk($sformatf("vec%0d_pc", idx), pc, v.exp_pc);
        end else begin
            reqs = 0;
            for (int i = 0; i < 6; i++) begin
                reqs += int'(imem_req);
                tick();
            end
            chk($sformatf("vec%0d_halt_reqs", idx), reqs, 32'd0);
            chk($sformatf("vec%0d_halt_valid", idx), 32'(instr_valid), 32'd0);
            chk($sformatf("vec%0d_pc_held", idx), pc, v.exp_pc);
        end
        chk($sformatf("vec%0d_err", idx), 32'(misalign_err), 32'(v.err));
        chk($sformatf("vec%0d_instret", idx), instret, v.exp_ir);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc[4];
        logic [31:0] ra[4];
        int nreq, reqs;
        bit pend;
        logic [31:0] pend_addr;

        vecs[0] = '{32'h10,        1, 0, 0, 1, 32'h40,  32'h0,   32'h40,  1'b0, 32'd2};
        vecs[1] = '{32'h10,        1, 0, 0, 0, 32'h40,  32'h0,   32'h14,  1'b0, 32'd2};
        vecs[2] = '{32'h0,         0, 1, 1, 0, 32'h40,  32'h81,  32'h80,  1'b0, 32'd1};
        vecs[3] = '{32'h0,         0, 1, 0, 0, 32'h200, 32'h0,   32'h200, 1'b0, 32'd1};
        vecs[4] = '{32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   1'b0, 32'd2};
        vecs[5] = '{32'h10,        0, 0, 0, 1, 32'h44,  32'h0,   32'h14,  1'b0, 32'd2};
        vecs[6] = '{32'h10,        1, 0, 0, 0, 32'h42,  32'h0,   32'h14,  1'b0, 32'd2};
        vecs[7] = '{32'h0,         1, 0, 1, 1, 32'h40,  32'h300, 32'h300, 1'b0, 32'd1};
        vecs[8] = '{32'h0,         1, 0, 0, 1, 32'h42,  32'h0,   32'h0,   1'b1, 32'd1};
        vecs[9] = '{32'h10,        0, 0, 1, 0, 32'h0,   32'h102, 32'h10,  1'b1, 32'd2};

        rst_n = 0; imem_rvalid = 0; imem_rdata = 0; clr_ctl();
        tick(); tick();

        // Reset state, first fetch and presentation
        do_reset();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_err", 32'(misalign_err), 32'd0);
        chk("rst_instret", instret, 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        tick();
        chk("first_req_pulse", 32'(imem_req), 32'd0);
        chk("first_wait_valid", 32'(instr_valid), 32'd0);
        imem_rvalid = 1; imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 0;
        chk("first_valid", 32'(instr_valid), 32'd1);
        chk("first_instr", instr, 32'h0050_0093);
        chk("first_opcode", 32'(OPcode), 32'h13);
        chk("first_pc", pc, 32'd0);
        chk("first_pc4", pc_plus4, 32'd4);
        tick();
        chk("first_hold", 32'(instr_valid), 32'd1);

        // Back-to-back sequential fetches with 1-cycle memory
        do_reset();
        instr_ready = 1; nreq = 0; pend = 0; pend_addr = 0;
        for (int c = 0; c < 11; c++) begin
            imem_rvalid = pend; imem_rdata = memword(pend_addr); pend = 0;
            if (imem_req) begin
                if (nreq < 4) begin
                    rc[nreq] = c;
                    ra[nreq] = imem_addr;
                end
                nreq++;
                pend = 1; pend_addr = imem_addr;
            end
            tick();
        end
        instr_ready = 0; imem_rvalid = 0;
        chk("seq_nreq", nreq, 32'd4);
        chk("seq_addr0", ra[0], 32'h0);
        chk("seq_addr1", ra[1], 32'h4);
        chk("seq_addr2", ra[2], 32'h8);
        chk("seq_gap01", rc[1] - rc[0], 32'd3);
        chk("seq_gap12", rc[2] - rc[1], 32'd3);
        chk("seq_instret", instret, 32'd3);

        // Slow memory with a stray rvalid during the request cycle
        do_reset();
        tick();
        chk("slow_req", 32'(imem_req), 32'd1);
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 0; reqs = 0;
        for (int i = 1; i < 4; i++) begin
            chk("slow_wait_valid", 32'(instr_valid), 32'd0);
            reqs += int'(imem_req);
            tick();
        end
        chk("slow_wait_valid", 32'(instr_valid), 32'd0);
        reqs += int'(imem_req);
        imem_rvalid = 1; imem_rdata = memword(32'h0);
        tick();
        imem_rvalid = 0;
        reqs += int'(imem_req);
        chk("slow_valid", 32'(instr_valid), 32'd1);
        chk("slow_instr", instr, memword(32'h0));
        tick();
        reqs += int'(imem_req);
        chk("slow_hold_instr", instr, memword(32'h0));
        chk("slow_single_req", reqs, 32'd0);

        // Reset during WAIT, late response lands in IDLE
        do_reset();
        tick(); tick();
        rst_n = 0;
        tick();
        rst_n = 1; imem_rvalid = 1; imem_rdata = 32'hBAD0_0001;
        chk("abort_idle_valid", 32'(instr_valid), 32'd0);
        tick();
        imem_rvalid = 0;
        chk("abort_req", 32'(imem_req), 32'd1);
        chk("abort_addr", imem_addr, 32'd0);
        tick();
        chk("abort_wait_valid", 32'(instr_valid), 32'd0);
        chk("abort_wait_instr", instr, NOP);
        imem_rvalid = 1; imem_rdata = 32'h0010_0113;
        tick();
        imem_rvalid = 0;
        chk("abort_valid", 32'(instr_valid), 32'd1);
        chk("abort_instr", instr, 32'h0010_0113);

        // Next-PC selection and misalignment table
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Halted with misalign_err set: reset must clear it
        do_reset();
        chk("halt_rst_err", 32'(misalign_err), 32'd0);
        chk("halt_rst_pc", pc, 32'd0);
        chk("halt_rst_instret", instret, 32'd0);

        // Randomized run against a transaction-level model
        begin
            logic [31:0] m_pc, m_ir, m_instr, np, resp_data, e_instr;
            logic        m_err, m_valid, m_wait, was_req;
            int          req_cd, resp_cd;
            do_reset();
            m_pc = 0; m_ir = 0; m_err = 0; m_valid = 0; m_wait = 0; m_instr = NOP;
            req_cd = 2; resp_cd = 0; resp_data = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                e_instr = m_valid ? m_instr : NOP;
                chk("rnd_req", 32'(imem_req), 32'(req_cd == 1));
                chk("rnd_addr", imem_addr, m_pc);
                chk("rnd_pc", pc, m_pc);
                chk("rnd_pc4", pc_plus4, m_pc + 32'd4);
                chk("rnd_valid", 32'(instr_valid), 32'(m_valid));
                chk("rnd_instr", instr, e_instr);
                chk("rnd_opcode", 32'(OPcode), 32'(e_instr[6:0]));
                chk("rnd_instret", instret, m_ir);
                chk("rnd_err", 32'(misalign_err), 32'(m_err));

                rst_n = ($urandom_range(0, 199) != 0);
                if (resp_cd == 1) begin
                    imem_rvalid = 1; imem_rdata = resp_data;
                end else if (!m_wait && $urandom_range(0, 3) == 0) begin
                    imem_rvalid = 1; imem_rdata = $urandom;
                end else begin
                    imem_rvalid = 0; imem_rdata = $urandom;
                end
                instr_ready  = ($urandom_range(0, 2) != 0);
                branch       = $urandom_range(0, 1);
                jump         = ($urandom_range(0, 3) == 0);
                jalr         = ($urandom_range(0, 3) == 0);
                branch_taken = $urandom_range(0, 1);
                branch_target = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                if ($urandom_range(0, 39) == 0) branch_target[1:0] = 2'($urandom_range(1, 3));
                jalr_target = {$urandom_range(0, 32'h3FFF_FFFF), 1'b0, 1'($urandom_range(0, 1))};
                if ($urandom_range(0, 39) == 0) jalr_target[1] = 1'b1;

                was_req = (req_cd == 1);
                if (!rst_n) begin
                    m_pc = 0; m_ir = 0; m_err = 0; m_valid = 0; m_wait = 0; m_instr = NOP;
                    req_cd = 2; resp_cd = 0;
                end else begin
                    if (req_cd > 0) req_cd--;
                    if (resp_cd > 0) resp_cd--;
                    if (was_req) begin
                        m_wait = 1;
                        resp_cd = $urandom_range(1, 5);
                        resp_data = memword(imem_addr);
                    end else if (m_wait && imem_rvalid) begin
                        m_wait = 0; m_valid = 1; m_instr = imem_rdata;
                    end else if (m_valid && instr_ready) begin
                        m_valid = 0;
                        m_ir = m_ir + 32'd1;
                        if (jalr)                       np = jalr_target & 32'hFFFF_FFFE;
                        else if (jump)                  np = branch_target;
                        else if (branch && branch_taken) np = branch_target;
                        else                            np = m_pc + 32'd4;
                        if (np % 4 != 0) m_err = 1;
                        else begin
                            m_pc = np;
                            req_cd = 1;
                        end
                    end
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
